// File: rtl/l2_burst_responder.sv
// Responder side of the L1-to-L2 line interface: turns one cacheline read or
// write request into a BEATS x BEAT_WIDTH burst on the physical-memory port.
module l2_burst_responder #(
  parameter int BEATS       = 4,
  parameter int BEAT_WIDTH  = 64,
  parameter int OFFSET_BITS = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          go_read,
  input  logic                          go_write,
  input  logic [31:0]                   go_address,
  input  logic [BEATS*BEAT_WIDTH-1:0]   go_wdata,
  output logic                          ret_resp,
  output logic [BEATS*BEAT_WIDTH-1:0]   ret_rdata,
  output logic [31:0]                   pmem_address_o,
  output logic                          pmem_read_o,
  output logic                          pmem_write_o,
  output logic [BEAT_WIDTH-1:0]         pmem_wdata_o,
  input  logic [BEAT_WIDTH-1:0]         pmem_rdata_i,
  input  logic                          pmem_resp_i
);

  localparam int LINE_WIDTH = BEATS * BEAT_WIDTH;
  localparam int CNT_WIDTH  = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_DONE
  } state_t;

  state_t                 state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [LINE_WIDTH-1:0]  line_buf;
  logic [LINE_WIDTH-1:0]  next_line;
  logic                   last_beat;
  logic [31:0]            aligned_address;

  assign last_beat       = (cnt == CNT_WIDTH'(BEATS - 1));
  assign aligned_address = go_address & ~((32'd1 << OFFSET_BITS) - 32'd1);

  // Read line with the current beat merged in; becomes ret_rdata on the last beat.
  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    next_line = line_buf;
    next_line[cnt*BEAT_WIDTH +: BEAT_WIDTH] = pmem_rdata_i;
  end

  // Write beats are taken live from go_wdata, selected by the beat counter.
  assign pmem_wdata_o = (state == ST_WR) ? go_wdata[cnt*BEAT_WIDTH +: BEAT_WIDTH]
                                         : '0;

  // NOTE: the line buffer is pure datapath with no reset; every read fills all beats before the line is published.
  always_ff @(posedge clk) begin
    if (state == ST_RD && pmem_resp_i) begin
      line_buf <= next_line;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      ret_resp       <= 1'b0;
      ret_rdata      <= '0;
      pmem_address_o <= '0;
      pmem_read_o    <= 1'b0;
      pmem_write_o   <= 1'b0;
    end else begin
      ret_resp <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          // Read wins if both requests are raised together.
          if (go_read) begin
            state          <= ST_RD;
            pmem_read_o    <= 1'b1;
            pmem_address_o <= aligned_address;
            cnt            <= '0;
          end else if (go_write) begin
            state          <= ST_WR;
            pmem_write_o   <= 1'b1;
            pmem_address_o <= aligned_address;
            cnt            <= '0;
          end
        end
        ST_RD: begin
          if (pmem_resp_i) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              ret_rdata   <= next_line;
              pmem_read_o <= 1'b0;
              ret_resp    <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_WR: begin
          if (pmem_resp_i) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              pmem_write_o <= 1'b0;
              ret_resp     <= 1'b1;
              state        <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
